reg_op_sequencer: RTL and testbench
===================================

# reg_op_sequencer

Upstream command sequencer for the 4-bit multi-function register stage. It accepts opcode commands over a valid/ready handshake and buffers them in a small FIFO. It then drives the register's one-hot control strobes (en/inc/dec/shl/shr) and load data, one operation per clock, with an optional repeat count per command.

## Interface
- `FIFO_DEPTH`, default 4: command buffer entries; power of two, at least 2.
- `DATA_W`, default 4: load-data width; matches the downstream register width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: the FIFO can accept a command; equals !full.
- `cmd_op` in 3: opcode. 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 SHL, 5 SHR, 6–7 reserved, executed as NOP.
- `cmd_data` in DATA_W: load value, used by LOAD only.
- `cmd_count` in 2: repeat field; the command executes cmd_count+1 times.
- `hold` in 1: freezes issue; the FIFO still accepts commands.
- `en`, `inc`, `dec`, `shl`, `shr` out 1 each: registered control strobes to the register stage. At most one is high in any cycle.
- `reg_in` out DATA_W: registered load data, valid whenever `en`=1.
- `done` out 1: one-cycle pulse in the cycle the final repetition of a command is driven.
- `busy` out 1: high when the state is ISSUE or the FIFO is non-empty.

## Operation
- **Accept:** a command is written into the FIFO at a rising edge where cmd_valid && cmd_ready. A write while full cannot occur because cmd_ready is low.
- **FSM states:** IDLE and ISSUE.
- **IDLE:**
  - If the FIFO is non-empty and hold=0, pop the head, load `rem` ← count, register the strobe for the opcode, and go to ISSUE.
  - Otherwise all strobes are 0.
- **ISSUE:**
  - If rem>0: re-drive the same strobe (LOAD re-drives the same data) and decrement rem.
  - If rem==0 and the FIFO is non-empty: pop the next command in the same cycle, with no bubble.
  - If rem==0 and the FIFO is empty: go to IDLE with strobes at 0.
- **NOP:** occupies count+1 cycles with all strobes at 0. `done` still pulses on its last cycle.
- **hold=1:** at the next edge all strobes go to 0. rem, state and the FIFO head are frozen. Issue resumes exactly where it stopped once hold=0. Held cycles do not count as repetitions.
- **Push and pop in the same edge:** both take effect, and occupancy is unchanged.
- **FIFO pointers:** wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer MSB.
- **reset low (any time, including mid-repeat):** flush the FIFO, state ← IDLE, rem ← 0. All strobes, reg_in, done and busy ← 0. cmd_ready ← 1.

## Timing
- Latency from idle: a command accepted at edge E0 is popped at E1. Its strobe is high during the cycle after E1 and is sampled by the register at E2.
- Sustained throughput: one strobe per cycle.
- cmd_ready is combinational from the FIFO count only. It never depends on cmd_valid.
- All other outputs are registered.

## Configuration
- `REG_SEQ_REPEAT_EN` defined: cmd_count is honoured, so each command runs cmd_count+1 times.
- `REG_SEQ_REPEAT_EN` undefined:
  - cmd_count is ignored and not stored in the FIFO; every command executes exactly once.
  - The rem counter is removed, and `done` pulses with every strobe cycle.

## Structure
- **Shared package `reg_seq_pkg`:**
  - Opcode enum (OP_NOP…OP_SHR).
  - FSM state typedef.
  - Command struct {op, data, count}.
  - DATA_W default constant.
- **Sub-module `reg_cmd_fifo`:** a synchronous FIFO parameterised by depth and width. It provides push, pop, full, empty and head data with first-word-fall-through (show-ahead) read.

## Test plan
- Reset, then single LOAD data=4'hA, count=0: en=1, reg_in=4'hA for exactly 1 cycle, starting 2 cycles after acceptance. done pulses with it, and busy falls the next cycle.
- INC count=3: inc high for 4 consecutive cycles, done only on the 4th. With the macro undefined, inc is high for 1 cycle.
- Push 5 commands back-to-back with DEPTH=4 and the FSM held: cmd_ready drops after 4 accepts. Release hold: strobes follow in order LOAD, SHL, SHR, DEC with no idle cycle between them.
- hold asserted mid-repeat of DEC count=3 after 2 pulses: strobes go to 0 while held. After release, exactly 2 more dec pulses, then done.
- NOP count=2 between INC and SHL: inc, then 3 zero cycles, then shl. done pulses at the end of each command.
- reset asserted during repeat with 2 entries queued: all outputs 0 immediately, the FIFO is empty after release, and no stale strobe appears afterwards.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared types and helpers for the register-operation sequencer.
// Build option: define REG_SEQ_REPEAT_EN to honour the per-command repeat count.
package reg_seq_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int CNT_W      = 2;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5
  } op_t;

  // FSM state encoding kept as plain constants for legacy tools
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_ISSUE = 1'b1;

  // op is kept as raw bits so the reserved opcodes 6 and 7 stay representable
  typedef struct packed {
    logic [2:0]            op;
    logic [DEF_DATA_W-1:0] data;
    logic [CNT_W-1:0]      count;
  } cmd_t;

  // One-hot strobe vector {shr, shl, dec, inc, en}; NOP and reserved give all zero
  function automatic logic [4:0] op_strobe(input logic [2:0] op);
    logic [4:0] s;
    s = 5'b00000;
    case (op)
      OP_LOAD: s = 5'b00001;
      OP_INC:  s = 5'b00010;
      OP_DEC:  s = 5'b00100;
      OP_SHL:  s = 5'b01000;
      OP_SHR:  s = 5'b10000;
      default: s = 5'b00000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_cmd_fifo.sv
// Show-ahead synchronous FIFO for sequencer commands.
// Pointers carry one extra MSB so that full and empty can be told apart.
module reg_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointer update; reset empties the buffer by aligning both pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/reg_op_sequencer.sv
// Command sequencer driving the one-hot control strobes of the 4-bit register stage.
// Build option: REG_SEQ_REPEAT_EN enables the cmd_count repeat field and the rem counter.
module reg_op_sequencer
  import reg_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [1:0]        cmd_count,
  input  logic              hold,
  output logic              en,
  output logic              inc,
  output logic              dec,
  output logic              shl,
  output logic              shr,
  output logic [DATA_W-1:0] reg_in,
  output logic              done,
  output logic              busy
);

`ifdef REG_SEQ_REPEAT_EN
  localparam int ENTRY_W = 3 + DATA_W + CNT_W;
`else
  localparam int ENTRY_W = 3 + DATA_W;
`endif

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] head;
  logic [2:0]         head_op;
  logic [DATA_W-1:0]  head_data;
  logic               rem_zero;
  state_t             state;
  logic [4:0]         strobe;

  assign head_op   = head[ENTRY_W-1 -: 3];
  assign head_data = head[ENTRY_W-4 -: DATA_W];

`ifdef REG_SEQ_REPEAT_EN
  logic [CNT_W-1:0] head_count;
  logic [CNT_W-1:0] rem;
  logic [2:0]       cur_op;
  assign wdata      = {cmd_op, cmd_data, cmd_count};
  assign head_count = head[CNT_W-1:0];
  assign rem_zero   = (rem == '0);
`else
  logic unused_count;
  assign unused_count = ^cmd_count;
  assign wdata        = {cmd_op, cmd_data};
  assign rem_zero     = 1'b1;
`endif

  assign push      = cmd_valid && !fifo_full;
  assign cmd_ready = !fifo_full;
  assign pop       = !hold && !fifo_empty && ((state == ST_IDLE) || rem_zero);
  assign busy      = (state == ST_ISSUE) || !fifo_empty;
  assign {shr, shl, dec, inc, en} = strobe;

  reg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue FSM: hold freezes everything but the strobes, repeats re-drive the
  // current op, and a finished command hands straight over to the next head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      strobe <= '0;
      reg_in <= '0;
      done   <= 1'b0;
`ifdef REG_SEQ_REPEAT_EN
      rem    <= '0;
      cur_op <= '0;
`endif
    end else if (hold) begin
      strobe <= '0;
      done   <= 1'b0;
`ifdef REG_SEQ_REPEAT_EN
    end else if ((state == ST_ISSUE) && !rem_zero) begin
      strobe <= op_strobe(cur_op);
      rem    <= rem - 1'b1;
      done   <= (rem == CNT_W'(1));
`endif
    end else if (pop) begin
      state  <= ST_ISSUE;
      strobe <= op_strobe(head_op);
      if (head_op == OP_LOAD) reg_in <= head_data;
`ifdef REG_SEQ_REPEAT_EN
      cur_op <= head_op;
      rem    <= head_count;
      done   <= (head_count == '0);
`else
      done   <= 1'b1;
`endif
    end else begin
      state  <= ST_IDLE;
      strobe <= '0;
      done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Randomised self-checking bench for reg_op_sequencer against a queue-based model.
// Honours REG_SEQ_REPEAT_EN the same way as the design build.
module tb_reg_op_sequencer;
  import reg_seq_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [1:0] cmd_count;
  logic       hold;
  logic       en, inc, dec, shl, shr;
  logic [3:0] reg_in;
  logic       done;
  logic       busy;

  int checks;
  int failures;

  // Reference model state: pending commands and the command being issued
  cmd_t       mq[$];
  int         reps_left;
  logic [2:0] cur_op;
  logic [3:0] cur_data;
  bit         in_issue;
  logic [4:0] exp_strobe;
  logic [3:0] exp_reg_in;
  bit         exp_done;
  bit         exp_busy;

  reg_op_sequencer #(.FIFO_DEPTH(DEPTH), .DATA_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .hold      (hold),
    .en        (en),
    .inc       (inc),
    .dec       (dec),
    .shl       (shl),
    .shr       (shr),
    .reg_in    (reg_in),
    .done      (done),
    .busy      (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [4:0] strobeOf(input logic [2:0] op);
    case (op)
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00010;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b01000;
      3'd5:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic modelReset();
    mq.delete();
    reps_left  = 0;
    cur_op     = 3'd0;
    cur_data   = 4'd0;
    in_issue   = 1'b0;
    exp_strobe = 5'b0;
    exp_reg_in = 4'd0;
    exp_done   = 1'b0;
    exp_busy   = 1'b0;
  endtask

  task automatic modelIssue();
    exp_strobe = strobeOf(cur_op);
    if (cur_op == 3'd1) exp_reg_in = cur_data;
    reps_left--;
    exp_done = (reps_left == 0);
  endtask

  // Predict outputs after the coming rising edge from the inputs now applied
  task automatic modelStep();
    bit   do_push;
    cmd_t c;
    do_push = cmd_valid && (mq.size() < DEPTH);
    if (hold) begin
      exp_strobe = 5'b0;
      exp_done   = 1'b0;
    end else if (reps_left > 0) begin
      modelIssue();
    end else if (mq.size() > 0) begin
      c        = mq.pop_front();
      cur_op   = c.op;
      cur_data = c.data;
`ifdef REG_SEQ_REPEAT_EN
      reps_left = int'(c.count) + 1;
`else
      reps_left = 1;
`endif
      in_issue = 1'b1;
      modelIssue();
    end else begin
      exp_strobe = 5'b0;
      exp_done   = 1'b0;
      in_issue   = 1'b0;
    end
    if (do_push) mq.push_back('{op: cmd_op, data: cmd_data, count: cmd_count});
    exp_busy = in_issue || (mq.size() > 0);
  endtask

  task automatic checkAll();
    checkOutput("strobes", {27'd0, shr, shl, dec, inc, en}, {27'd0, exp_strobe});
    checkOutput("reg_in", {28'd0, reg_in}, {28'd0, exp_reg_in});
    checkOutput("done", {31'd0, done}, {31'd0, exp_done});
    checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
    checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, (mq.size() < DEPTH)});
  endtask

  // Called at a falling edge: check, drive, predict, advance one cycle
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [3:0] d,
                               input logic [1:0] c, input logic h);
    checkAll();
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = c;
    hold      = h;
    modelStep();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic h);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 4'd0, 2'd0, h);
  endtask

  // Asynchronous reset pulse starting at a falling edge
  task automatic doReset();
    checkAll();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    hold      = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_count = 2'd0;
    hold      = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkAll();
    reset = 1'b1;

    // Single LOAD of A
    applyStimulus(1'b1, 3'd1, 4'hA, 2'd0, 1'b0);
    idleCycles(4, 1'b0);

    // INC repeated
    applyStimulus(1'b1, 3'd2, 4'h0, 2'd3, 1'b0);
    idleCycles(6, 1'b0);

    // Fill the buffer while held, fifth push refused
    applyStimulus(1'b1, 3'd1, 4'h5, 2'd0, 1'b1);
    applyStimulus(1'b1, 3'd4, 4'h0, 2'd0, 1'b1);
    applyStimulus(1'b1, 3'd5, 4'h0, 2'd0, 1'b1);
    applyStimulus(1'b1, 3'd3, 4'h0, 2'd0, 1'b1);
    checkOutput("ready_full", {31'd0, cmd_ready}, 32'd0);
    applyStimulus(1'b1, 3'd2, 4'h0, 2'd0, 1'b1);
    idleCycles(8, 1'b0);

    // Hold in the middle of a DEC repeat
    applyStimulus(1'b1, 3'd3, 4'h0, 2'd3, 1'b0);
    idleCycles(2, 1'b0);
    idleCycles(3, 1'b1);
    idleCycles(5, 1'b0);

    // INC, NOP x3, SHL back-to-back
    applyStimulus(1'b1, 3'd2, 4'h0, 2'd0, 1'b0);
    applyStimulus(1'b1, 3'd0, 4'h0, 2'd2, 1'b0);
    applyStimulus(1'b1, 3'd4, 4'h0, 2'd0, 1'b0);
    idleCycles(8, 1'b0);

    // Reset in the middle of a repeat with entries still queued
    applyStimulus(1'b1, 3'd2, 4'h0, 2'd3, 1'b0);
    applyStimulus(1'b1, 3'd3, 4'h0, 2'd1, 1'b0);
    applyStimulus(1'b1, 3'd1, 4'h7, 2'd0, 1'b0);
    doReset();
    idleCycles(5, 1'b0);
    checkOutput("busy_after_rst", {31'd0, busy}, 32'd0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(149) == 0) doReset();
      else applyStimulus(1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom),
                         2'($urandom_range(3)), 1'($urandom_range(6) == 0));
    end
    idleCycles(12, 1'b0);
    checkAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
